fsm_seq_checker: RTL

//  Receiving end of the Start->One->Two->Three->Finish state sequence produced by our sequencer FSMs.

---
 rtl/fsm_seq_checker.sv | 105 ++++++++++
 1 files changed

// File: rtl/fsm_seq_checker.sv
// fsm_seq_checker: checks a Start(x WAIT_DELAY+1)->One->Two->Three->Finish(held) state stream.
// Optional idle timeout in START/SEQ is enabled by defining FSM_CHECK_TIMEOUT_EN.
module fsm_seq_checker #(
    parameter int WAIT_DELAY = 5,
    parameter int STEP_W     = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_valid,
    input  logic [2:0]        in_state,
    input  logic              in_clear,
    output logic              out_armed,
    output logic              out_done,
    output logic              out_err,
    output logic [2:0]        out_err_code,
    output logic [STEP_W-1:0] out_step
);
    localparam int CW = $clog2(WAIT_DELAY + 2) + 1;
    localparam logic [CW-1:0] START_LEN = CW'(WAIT_DELAY + 1);
    typedef enum logic [2:0] {IDLE, START, SEQ, DONE, ERROR} state_t;
    state_t            state;
    logic [CW-1:0]     start_ctr;
    logic [2:0]        exp_code;
    logic [2:0]        err_nxt;
    logic [STEP_W-1:0] step_inc;
    logic              illegal, at_len;
    assign illegal  = in_state > 3'd4;
    assign at_len   = start_ctr == START_LEN;
    assign step_inc = &out_step ? out_step : out_step + 1'b1;
`ifdef FSM_CHECK_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_ctr;
    always_ff @(posedge in_clk) begin
        if (!in_rst_n || in_clear || in_valid || !(state == START || state == SEQ))
            idle_ctr <= '0;
        else
            idle_ctr <= idle_ctr + 1'b1;
    end
`endif
    // First error code decided by this cycle's sample (0 = none)
    always_comb begin
        err_nxt = 3'd0;
        if (in_valid)
            case (state)
                START:   err_nxt = illegal ? 3'd4 : in_state == 3'd0 ? (at_len ? 3'd1 : 3'd0) :
                                   in_state == 3'd1 ? (at_len ? 3'd0 : 3'd2) : 3'd3;
                SEQ:     err_nxt = in_state == exp_code ? 3'd0 : illegal ? 3'd4 : 3'd3;
                DONE:    err_nxt = in_state == 3'd4 ? 3'd0 : 3'd5;
                default: err_nxt = 3'd0;
            endcase
`ifdef FSM_CHECK_TIMEOUT_EN
        else if ((state == START || state == SEQ) && idle_ctr == IW'(TIMEOUT - 1))
            err_nxt = 3'd6;
`endif
    end
    always_ff @(posedge in_clk) begin
        if (!in_rst_n || in_clear) begin
            state        <= IDLE;
            start_ctr    <= '0;
            exp_code     <= 3'd0;
            out_armed    <= 1'b0;
            out_done     <= 1'b0;
            out_err      <= 1'b0;
            out_err_code <= 3'd0;
            out_step     <= '0;
        end else if (err_nxt != 3'd0) begin
            state        <= ERROR;
            out_armed    <= 1'b0;
            out_done     <= 1'b0;
            out_err      <= 1'b1;
            out_err_code <= err_nxt;
            if (in_valid)
                out_step <= step_inc;
        end else if (in_valid) begin
            case (state)
                IDLE: if (in_state == 3'd0) begin
                    state     <= START;
                    start_ctr <= CW'(1);
                    out_armed <= 1'b1;
                    out_step  <= STEP_W'(1);
                end
                START: begin
                    out_step <= step_inc;
                    if (in_state == 3'd0)
                        start_ctr <= start_ctr + 1'b1;
                    else begin
                        state    <= SEQ;
                        exp_code <= 3'd2;
                    end
                end
                SEQ: begin
                    out_step <= step_inc;
                    exp_code <= exp_code + 1'b1;
                    if (in_state == 3'd4) begin
                        state    <= DONE;
                        out_done <= 1'b1;
                    end
                end
                DONE:    out_step <= step_inc;
                default: ;
            endcase
        end
    end
endmodule
